// File: rtl/minisrc_datapath.sv
// minisrc_datapath
// ----------------
// 32-bit single-bus Mini SRC datapath slice: R0, R4, R5, PC, IR, MAR, MDR,
// Y, a 64-bit Z register (Zhigh:Zlow), one shared bus and a combinational
// ALU. Every load enable, bus drive select and the ALU opcode come straight
// from the control unit (or a bench during bring-up).
//
// Ports
//   clk                     rising-edge clock for all state
//   clr                     synchronous active-high clear, beats every load enable
//   R0_in..Z_in             per-register load enables (register <= bus)
//   Read                    MDR source select: 1 = Mdatain, 0 = bus
//   R4_out..MDR_out         bus drive selects, priority MDR > Zlow > PC > R5 > R4
//   alu_instruction [4:0]   ALU opcode (IR[31:27] encoding)
//   Mdatain [WIDTH-1:0]     memory read data
//   Bus_Data                live bus value (combinational)
//   *_Data                  register contents; Zhigh/Zlow are Z[63:32]/Z[31:0]
//
// Build option
//   DATAPATH_MULDIV_EN      when defined, opcodes 01111 (signed mul) and
//                           10000 (signed div/rem) are implemented; otherwise
//                           both yield Z = 0 and no mul/div hardware exists.
//
// There are no handshakes: every strobe acts on the next rising edge only.

module minisrc_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             R0_in,
    input  logic             R4_in,
    input  logic             R5_in,
    input  logic             PC_in,
    input  logic             IR_in,
    input  logic             MAR_in,
    input  logic             MDR_in,
    input  logic             Y_in,
    input  logic             Z_in,
    input  logic             Read,
    input  logic             R4_out,
    input  logic             R5_out,
    input  logic             PC_out,
    input  logic             Zlow_out,
    input  logic             MDR_out,
    input  logic [4:0]       alu_instruction,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] Bus_Data,
    output logic [WIDTH-1:0] R0_Data,
    output logic [WIDTH-1:0] R4_Data,
    output logic [WIDTH-1:0] R5_Data,
    output logic [WIDTH-1:0] PC_Data,
    output logic [WIDTH-1:0] IR_Data,
    output logic [WIDTH-1:0] MAR_Data,
    output logic [WIDTH-1:0] MDR_Data,
    output logic [WIDTH-1:0] Y_Data,
    output logic [WIDTH-1:0] Zhigh_Data,
    output logic [WIDTH-1:0] Zlow_Data
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_INC  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [WIDTH-1:0]   r0_q, r0_d, r4_q, r4_d, r5_q, r5_d;
    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d, y_q, y_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   alu_a, alu_b;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic [2*WIDTH-1:0] alu_result;

    // Fixed-priority bus mux; an undriven bus reads as zero.
    always_comb begin
        bus = '0;
        if (MDR_out)       bus = mdr_q;
        else if (Zlow_out) bus = z_q[WIDTH-1:0];
        else if (PC_out)   bus = pc_q;
        else if (R5_out)   bus = r5_q;
        else if (R4_out)   bus = r4_q;
    end

    assign alu_a = y_q;
    assign alu_b = bus;
    assign shamt = alu_b[SHW-1:0];

    // Rotates via a doubled operand: the low half of {A,A}>>n is A rotated
    // right by n, the high half of {A,A}<<n is A rotated left by n.
    assign rot_r = {alu_a, alu_a} >> shamt;
    assign rot_l = {alu_a, alu_a} << shamt;

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic        [WIDTH-1:0]   quot, rem;

    assign ext_a = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
    assign ext_b = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
    assign prod  = ext_a * ext_b;
    // Dividing at double width keeps most-negative / -1 well defined; the
    // quotient then simply wraps to 32 bits. Remainder sign follows the dividend.
    assign quot  = (alu_b == '0) ? '0 : WIDTH'(ext_a / ext_b);
    assign rem   = (alu_b == '0) ? '0 : WIDTH'(ext_a % ext_b);
`endif

    always_comb begin
        alu_result = '0;
        case (alu_instruction)
            OP_INC:  alu_result[WIDTH-1:0] = alu_b + WIDTH'(1);
            OP_ADD:  alu_result[WIDTH-1:0] = alu_a + alu_b;
            OP_SUB:  alu_result[WIDTH-1:0] = alu_a - alu_b;
            OP_AND:  alu_result[WIDTH-1:0] = alu_a & alu_b;
            OP_OR:   alu_result[WIDTH-1:0] = alu_a | alu_b;
            OP_SHR:  alu_result[WIDTH-1:0] = alu_a >> shamt;
            OP_SHRA: alu_result[WIDTH-1:0] = $signed(alu_a) >>> shamt;
            OP_SHL:  alu_result[WIDTH-1:0] = alu_a << shamt;
            OP_ROR:  alu_result[WIDTH-1:0] = rot_r[WIDTH-1:0];
            OP_ROL:  alu_result[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
            OP_NEG:  alu_result[WIDTH-1:0] = -alu_b;
            OP_NOT:  alu_result[WIDTH-1:0] = ~alu_b;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  alu_result = prod;
            OP_DIV:  alu_result = {rem, quot};
`else
            OP_MUL:  alu_result = '0;
            OP_DIV:  alu_result = '0;
`endif
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        r0_d  = r0_q;
        r4_d  = r4_q;
        r5_d  = r5_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        y_d   = y_q;
        z_d   = z_q;
        if (R0_in)  r0_d  = bus;
        if (R4_in)  r4_d  = bus;
        if (R5_in)  r5_d  = bus;
        if (PC_in)  pc_d  = bus;
        if (IR_in)  ir_d  = bus;
        if (MAR_in) mar_d = bus;
        if (MDR_in) mdr_d = Read ? Mdatain : bus;
        if (Y_in)   y_d   = bus;
        if (Z_in)   z_d   = alu_result;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r0_q  <= '0;
            r4_q  <= '0;
            r5_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            r0_q  <= r0_d;
            r4_q  <= r4_d;
            r5_q  <= r5_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign Bus_Data   = bus;
    assign R0_Data    = r0_q;
    assign R4_Data    = r4_q;
    assign R5_Data    = r5_q;
    assign PC_Data    = pc_q;
    assign IR_Data    = ir_q;
    assign MAR_Data   = mar_q;
    assign MDR_Data   = mdr_q;
    assign Y_Data     = y_q;
    assign Zhigh_Data = z_q[2*WIDTH-1:WIDTH];
    assign Zlow_Data  = z_q[WIDTH-1:0];

endmodule

// File: tb/tb_minisrc_datapath.sv
// Bench for minisrc_datapath: directed steps from the bring-up sequence,
// bus priority sweep, simultaneous-event cases, then randomized ALU
// operations checked against an arithmetic reference model.

module tb_minisrc_datapath;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        R0_in, R4_in, R5_in, PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in;
    logic        Read;
    logic        R4_out, R5_out, PC_out, Zlow_out, MDR_out;
    logic [4:0]  alu_instruction;
    logic [31:0] Mdatain;
    logic [31:0] Bus_Data, R0_Data, R4_Data, R5_Data, PC_Data, IR_Data;
    logic [31:0] MAR_Data, MDR_Data, Y_Data, Zhigh_Data, Zlow_Data;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    minisrc_datapath #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr),
        .R0_in(R0_in), .R4_in(R4_in), .R5_in(R5_in), .PC_in(PC_in),
        .IR_in(IR_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .Y_in(Y_in), .Z_in(Z_in),
        .Read(Read),
        .R4_out(R4_out), .R5_out(R5_out), .PC_out(PC_out),
        .Zlow_out(Zlow_out), .MDR_out(MDR_out),
        .alu_instruction(alu_instruction), .Mdatain(Mdatain),
        .Bus_Data(Bus_Data), .R0_Data(R0_Data), .R4_Data(R4_Data),
        .R5_Data(R5_Data), .PC_Data(PC_Data), .IR_Data(IR_Data),
        .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .Y_Data(Y_Data),
        .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        clr = 0;
        R0_in = 0; R4_in = 0; R5_in = 0; PC_in = 0; IR_in = 0;
        MAR_in = 0; MDR_in = 0; Y_in = 0; Z_in = 0;
        Read = 0;
        R4_out = 0; R5_out = 0; PC_out = 0; Zlow_out = 0; MDR_out = 0;
        alu_instruction = 5'd0;
        Mdatain = 32'd0;
    endtask

    // One rising edge; outputs are sampled 1 time unit later, then strobes drop.
    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDR_in = 1;
        cycle();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_mdr(v);
        MDR_out = 1; Y_in = 1;
        cycle();
    endtask

    task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        set_y(a);
        load_mdr(b);
        MDR_out = 1; Z_in = 1; alu_instruction = op;
        cycle();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int s, ai, bi;
        longint ua, ub, sa, sb, p;
        logic [31:0] r;
        logic [63:0] w;
        s  = int'(b % 32);
        ai = a; bi = b;
        sa = ai; sb = bi;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 1;
        for (int i = 0; i < s; i++) p = p * 2;
        r = 32'd0;
        w = 64'd0;
        case (op)
            5'd0:  r = 32'(ub + 1);
            5'd3:  r = 32'(ua + ub);
            5'd4:  r = 32'(ua - ub);
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = 32'(ua / p);
            5'd8:  r = (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
            5'd9:  r = 32'(ua * p);
            5'd10: begin
                r = a;
                for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
            end
            5'd11: begin
                r = a;
                for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
            end
            5'd17: r = 32'(-ub);
            5'd18: r = ~b;
`ifdef DATAPATH_MULDIV_EN
            5'd15: w = 64'(sa * sb);
            5'd16: if (sb != 0) begin
                w[31:0]  = 32'(sa / sb);
                w[63:32] = 32'(sa % sb);
            end
`endif
            default: r = 32'd0;
        endcase
        if (op != 5'd15 && op != 5'd16) w = {32'd0, r};
        return w;
    endfunction

    // ---------------- stimulus ----------------
    logic [4:0]  ops [16] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd10, 5'd11, 5'd17, 5'd18, 5'd15, 5'd16, 5'd1, 5'd31};
    logic [31:0] v4, v5, vp, vz, vm, exp_bus, ra, rb;
    logic [63:0] exp_z;
    logic [4:0]  sel, rop;
    logic [4:0]  ir_op;

    initial begin
        idle();
        clr = 1;
        repeat (2) @(posedge clk);
        #1;
        idle();

        // Reset: load R4, then clear while enables are active.
        load_mdr(32'h1234);
        MDR_out = 1; R4_in = 1;
        cycle();
        check("pre_reset_r4", R4_Data, 32'h1234);
        clr = 1; MDR_out = 1; R4_in = 1; Z_in = 1; Y_in = 1;
        cycle();
        check("rst_r0", R0_Data, 0);     check("rst_r4", R4_Data, 0);
        check("rst_r5", R5_Data, 0);     check("rst_pc", PC_Data, 0);
        check("rst_ir", IR_Data, 0);     check("rst_mar", MAR_Data, 0);
        check("rst_mdr", MDR_Data, 0);   check("rst_y", Y_Data, 0);
        check("rst_zhi", Zhigh_Data, 0); check("rst_zlo", Zlow_Data, 0);
        check("rst_bus", Bus_Data, 0);

        // Register loads through MDR.
        load_mdr(32'hFA92);
        check("mdr_read", MDR_Data, 32'hFA92);
        MDR_out = 1; R4_in = 1;
        #1 check("bus_mdr", Bus_Data, 32'hFA92);
        cycle();
        check("r4_load", R4_Data, 32'hFA92);
        load_mdr(32'hFF);
        MDR_out = 1; R5_in = 1;
        cycle();
        check("r5_load", R5_Data, 32'hFF);
        load_mdr(32'h595);
        MDR_out = 1; R0_in = 1;
        cycle();
        check("r0_load", R0_Data, 32'h595);
        Mdatain = 32'hDEAD_BEEF;
        cycle();
        check("hold_r4", R4_Data, 32'hFA92);
        check("hold_mdr", MDR_Data, 32'h595);

        // Fetch.
        PC_out = 1; MAR_in = 1; Z_in = 1; alu_instruction = 5'b00000;
        cycle();
        check("fetch_mar", MAR_Data, 0);
        check("fetch_zlo", Zlow_Data, 1);
        Zlow_out = 1; PC_in = 1; Read = 1; MDR_in = 1; Mdatain = 32'h1822_8000;
        cycle();
        check("fetch_pc", PC_Data, 1);
        check("fetch_mdr", MDR_Data, 32'h1822_8000);
        MDR_out = 1; IR_in = 1;
        cycle();
        check("fetch_ir", IR_Data, 32'h1822_8000);
        ir_op = IR_Data[31:27];
        check("fetch_opcode", {27'd0, ir_op}, 32'd3);

        // Add R0 = R4 + R5.
        R4_out = 1; Y_in = 1;
        cycle();
        check("add_y", Y_Data, 32'hFA92);
        R5_out = 1; Z_in = 1; alu_instruction = 5'b00011;
        cycle();
        check("add_zlo", Zlow_Data, 32'hFB91);
        check("add_zhi", Zhigh_Data, 0);
        Zlow_out = 1; R0_in = 1;
        cycle();
        check("add_r0", R0_Data, 32'hFB91);

        // Z drives the bus and loads in the same edge: captures pre-edge value + 1.
        Zlow_out = 1; Z_in = 1; alu_instruction = 5'b00000;
        cycle();
        check("drive_load_z", Zlow_Data, 32'hFB92);

        // Several loads share one bus value.
        load_mdr(32'hA5A5_5A5A);
        MDR_out = 1; R0_in = 1; R4_in = 1; R5_in = 1; Y_in = 1; MAR_in = 1;
        cycle();
        check("multi_r0", R0_Data, 32'hA5A5_5A5A);
        check("multi_r4", R4_Data, 32'hA5A5_5A5A);
        check("multi_r5", R5_Data, 32'hA5A5_5A5A);
        check("multi_y", Y_Data, 32'hA5A5_5A5A);
        check("multi_mar", MAR_Data, 32'hA5A5_5A5A);

        // Shift / sub / logic directed values.
        run_alu(5'b01000, 32'h8000_0000, 32'd4);
        check("shra", Zlow_Data, 32'hF800_0000);
        check("shra_hi", Zhigh_Data, 0);
        run_alu(5'b00111, 32'h8000_0000, 32'd4);
        check("shr", Zlow_Data, 32'h0800_0000);
        run_alu(5'b01010, 32'h8000_0000, 32'd1);
        check("ror", Zlow_Data, 32'h4000_0000);
        run_alu(5'b00100, 32'h5, 32'h7);
        check("sub", Zlow_Data, 32'hFFFF_FFFE);
        run_alu(5'b01001, 32'h1234_5678, 32'h20);
        check("shl_amt0", Zlow_Data, 32'h1234_5678);
        run_alu(5'b01011, 32'h8000_0001, 32'd1);
        check("rol", Zlow_Data, 32'h0000_0003);
        run_alu(5'b10001, 32'h0, 32'd1);
        check("neg", Zlow_Data, 32'hFFFF_FFFF);
        run_alu(5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("bad_op", Zlow_Data, 0);

        // Multiply / divide.
`ifdef DATAPATH_MULDIV_EN
        exp_z = 64'hFFFF_FFFF_FFFF_FFFA;
`else
        exp_z = 64'd0;
`endif
        run_alu(5'b01111, 32'hFFFF_FFFE, 32'd3);
        check("mul_hi", Zhigh_Data, exp_z[63:32]);
        check("mul_lo", Zlow_Data, exp_z[31:0]);
`ifdef DATAPATH_MULDIV_EN
        exp_z = {32'd1, 32'd3};
`else
        exp_z = 64'd0;
`endif
        run_alu(5'b10000, 32'd7, 32'd2);
        check("div_rem", Zhigh_Data, exp_z[63:32]);
        check("div_quo", Zlow_Data, exp_z[31:0]);
        run_alu(5'b10000, 32'd7, 32'd0);
        check("div0_hi", Zhigh_Data, 0);
        check("div0_lo", Zlow_Data, 0);

        // Bus priority sweep over every select combination.
        v4 = $urandom; v5 = $urandom; vp = $urandom; vz = $urandom; vm = $urandom;
        load_mdr(v4); MDR_out = 1; R4_in = 1; cycle();
        load_mdr(v5); MDR_out = 1; R5_in = 1; cycle();
        load_mdr(vp); MDR_out = 1; PC_in = 1; cycle();
        load_mdr(vz); MDR_out = 1; Z_in = 1; alu_instruction = 5'd0; cycle();
        load_mdr(vm);
        for (int i = 0; i < 32; i++) begin
            sel = 5'(i);
            MDR_out = sel[4]; Zlow_out = sel[3]; PC_out = sel[2];
            R5_out = sel[1]; R4_out = sel[0];
            if (sel[4])      exp_bus = vm;
            else if (sel[3]) exp_bus = vz + 32'd1;
            else if (sel[2]) exp_bus = vp;
            else if (sel[1]) exp_bus = v5;
            else if (sel[0]) exp_bus = v4;
            else             exp_bus = 32'd0;
            #1;
            check($sformatf("bus_sel_%02h", sel), Bus_Data, exp_bus);
        end
        idle();

        // Randomized ALU operations against the model.
        for (int n = 0; n < 60; n++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            rop = ops[$urandom_range(0, 15)];
            exp_q.push_back(ref_alu(rop, ra, rb));
            run_alu(rop, ra, rb);
            exp_z = exp_q.pop_front();
            check($sformatf("rand_lo op=%0d a=%h b=%h", rop, ra, rb), Zlow_Data, exp_z[31:0]);
            check($sformatf("rand_hi op=%0d a=%h b=%h", rop, ra, rb), Zhigh_Data, exp_z[63:32]);
        end

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
